// File: rtl/smac_multi_seq_if.sv
// Handshake bundle for smac_multi_seq: input vector side (valid/ready/last + config + operands)
// and result side (valid/ready + data), plus busy status.
interface smac_multi_seq_if #(
  parameter int M  = 64,
  parameter int N  = 4,
  parameter int Pa = 8,
  parameter int Pw = 4,
  parameter int TG = 4
);
  localparam int OW = $clog2(M) + Pa + Pw + TG;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [$clog2(Pa):0]   pa_cfg;
  logic [$clog2(Pw):0]   pw_cfg;
  logic [M*Pa-1:0]       in_act;
  logic [N*M*Pw-1:0]     in_wei;
  logic                  out_valid;
  logic                  out_ready;
  logic [N*OW-1:0]       out_data;
  logic                  busy;

  modport master (
    output in_valid, in_last, pa_cfg, pw_cfg, in_act, in_wei, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_last, pa_cfg, pw_cfg, in_act, in_wei, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/smac_multi_seq.sv
// Bit-serial N-channel signed MAC: latches one vector, walks pa*pw bit-plane pairs, result pa*pw+1 edges later.
// No input buffering (in_ready low while busy); result held until out_ready. SMAC_RELU_EN zeroes negative outputs.
module smac_multi_seq #(
  parameter int M  = 64,
  parameter int N  = 4,
  parameter int Pa = 8,
  parameter int Pw = 4,
  parameter int TG = 4
) (
  input logic             clk,
  input logic             rst,
  smac_multi_seq_if.slave bus
);
  localparam int OW  = $clog2(M) + Pa + Pw + TG;
  localparam int PAW = $clog2(Pa) + 1;
  localparam int PWW = $clog2(Pw) + 1;
  localparam int IW  = (Pa > 1) ? $clog2(Pa) : 1;
  localparam int JW  = (Pw > 1) ? $clog2(Pw) : 1;
  localparam int CW  = $clog2(M + 1);
  localparam int SW  = $clog2(Pa + Pw) + 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUT} state_t;

  state_t               state;
  logic [M*Pa-1:0]      act_r;
  logic [N*M*Pw-1:0]    wei_r;
  logic                 last_r;
  logic                 first_r;
  logic [PAW-1:0]       pa;
  logic [PWW-1:0]       pw;
  logic [IW-1:0]        i;
  logic [JW-1:0]        j;
  logic                 i_top;
  logic                 j_top;
  logic [CW-1:0]        pc     [N];
  logic [CW-1:0]        pc_nxt [N];
  logic                 pc_vld;
  logic                 pc_neg;
  logic [SW-1:0]        pc_sh;
  logic signed [OW-1:0] term   [N];
  logic signed [OW-1:0] acc    [N];
  logic                 in_ready_r;
  logic                 out_valid_r;
  logic                 busy_r;
  logic [N*OW-1:0]      out_data_w;

  function automatic logic [PAW-1:0] clamp_pa(input logic [PAW-1:0] v);
    if (v == '0)          return PAW'(1);
    if (v > PAW'(Pa))     return PAW'(Pa);
    return v;
  endfunction

  function automatic logic [PWW-1:0] clamp_pw(input logic [PWW-1:0] v);
    if (v == '0)          return PWW'(1);
    if (v > PWW'(Pw))     return PWW'(Pw);
    return v;
  endfunction

  assign i_top = (PAW'(i) == pa - PAW'(1));
  assign j_top = (PWW'(j) == pw - PWW'(1));

  // Stage 1: per-channel popcount of the current activation/weight bit-plane pair.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      pc_nxt[c] = '0;
      for (int k = 0; k < M; k++) begin
        pc_nxt[c] = pc_nxt[c] + CW'(act_r[k*Pa + int'(i)] & wei_r[(c*M + k)*Pw + int'(j)]);
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N; c++) begin
      term[c] = OW'(pc[c]) << pc_sh;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      act_r       <= '0;
      wei_r       <= '0;
      last_r      <= 1'b0;
      first_r     <= 1'b1;
      pa          <= PAW'(Pa);
      pw          <= PWW'(Pw);
      i           <= '0;
      j           <= '0;
      pc_vld      <= 1'b0;
      pc_neg      <= 1'b0;
      pc_sh       <= '0;
      for (int c = 0; c < N; c++) begin
        pc[c]  <= '0;
        acc[c] <= '0;
      end
    end else begin
      pc_vld <= 1'b0;
      // Stage 2: a plane pair that mixes exactly one sign bit carries negative weight.
      if (pc_vld) begin
        for (int c = 0; c < N; c++) begin
          acc[c] <= pc_neg ? acc[c] - term[c] : acc[c] + term[c];
        end
      end
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            act_r  <= bus.in_act;
            wei_r  <= bus.in_wei;
            last_r <= bus.in_last;
            i      <= '0;
            j      <= '0;
            if (first_r) begin
              pa <= clamp_pa(bus.pa_cfg);
              pw <= clamp_pw(bus.pw_cfg);
            end
            first_r    <= 1'b0;
            state      <= COMPUTE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        COMPUTE: begin
          for (int c = 0; c < N; c++) begin
            pc[c] <= pc_nxt[c];
          end
          pc_vld <= 1'b1;
          pc_neg <= i_top ^ j_top;
          pc_sh  <= SW'(i) + SW'(j);
          if (i_top) begin
            i <= '0;
            if (j_top) begin
              j     <= '0;
              state <= DRAIN;
            end else begin
              j <= j + JW'(1);
            end
          end else begin
            i <= i + IW'(1);
          end
        end
        DRAIN: begin
          state       <= last_r ? OUT : IDLE;
          out_valid_r <= last_r;
          in_ready_r  <= ~last_r;
          busy_r      <= last_r;
        end
        OUT: begin
          if (bus.out_ready) begin
            for (int c = 0; c < N; c++) begin
              acc[c] <= '0;
            end
            first_r     <= 1'b1;
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_data_w = '0;
    for (int c = 0; c < N; c++) begin
`ifdef SMAC_RELU_EN
      out_data_w[c*OW +: OW] = acc[c][OW-1] ? '0 : acc[c];
`else
      out_data_w[c*OW +: OW] = acc[c];
`endif
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.out_data  = out_data_w;
endmodule
